// File: rtl/dmem_responder.sv
// Single-port data memory responder with a startup delay, fixed wait states and a one-cycle response pulse.
// Out-of-range or misaligned accesses complete with err=1 and never touch the memory.
//
// state   | meaning
// STARTUP | post-reset delay, no grants, ready low
// IDLE    | accept a request (gnt follows req)
// WAIT    | wait states for the latched transaction
// RESP    | rvalid/rdata/err presented for one cycle
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter int unsigned STARTUP_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        gnt,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        ready
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic             t_we;
    logic [31:0]      t_addr, t_wdata, t_off;
    logic [3:0]       t_be;
    logic             t_err;
    logic [IDX_W-1:0] t_idx;
    logic             enter_resp;

    // With zero wait states IDLE goes straight to RESP, so the live inputs stand in for the latch.
    always_comb begin
        if (state_q == ST_IDLE) begin
            t_we    = we;
            t_addr  = addr;
            t_wdata = wdata;
            t_be    = be;
        end else begin
            t_we    = we_q;
            t_addr  = addr_q;
            t_wdata = wdata_q;
            t_be    = be_q;
        end
        t_off = t_addr - BASE_ADDR;
        t_err = (t_addr[1:0] != 2'b00) || ({2'b00, t_off} >= {DEPTH_WORDS, 2'b00});
        t_idx = t_off[IDX_W+1:2];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_STARTUP;
            cnt_q    <= 4'(STARTUP_CYCLES - 1);
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (gnt) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
            rvalid_q <= enter_resp;
            rdata_q  <= (enter_resp && !t_we && !t_err) ? mem_q[t_idx] : 32'h0;
            err_q    <= enter_resp && t_err;
        end
    end

    // Memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (enter_resp && t_we && !t_err) begin
            for (int i = 0; i < 4; i++) begin
                if (t_be[i]) mem_q[t_idx][8*i +: 8] <= t_wdata[8*i +: 8];
            end
        end
    end

    assign gnt    = (state_q == ST_IDLE) && req;
    assign ready  = (state_q != ST_STARTUP);
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a default instance and a zero-wait, offset-base instance,
// both checked against an associative-array memory model.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] BASE_B  = 32'h8000_0100;
    localparam int          DEPTH_B = 64;

    logic        rst, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    int          sel;

    logic        req_a, req_b;
    logic        gnt_a, rvalid_a, err_a, ready_a;
    logic        gnt_b, rvalid_b, err_b, ready_b;
    logic [31:0] rdata_a, rdata_b;
    logic        gnt_m, rvalid_m, err_m;
    logic [31:0] rdata_m;

    assign req_a    = req && (sel == 0);
    assign req_b    = req && (sel == 1);
    assign gnt_m    = (sel == 0) ? gnt_a    : gnt_b;
    assign rvalid_m = (sel == 0) ? rvalid_a : rvalid_b;
    assign err_m    = (sel == 0) ? err_a    : err_b;
    assign rdata_m  = (sel == 0) ? rdata_a  : rdata_b;

    dmem_responder u_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .err(err_a), .ready(ready_a)
    );

    dmem_responder #(
        .DEPTH_WORDS(DEPTH_B), .BASE_ADDR(BASE_B), .WAIT_CYCLES(0), .STARTUP_CYCLES(3)
    ) u_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .err(err_b), .ready(ready_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_mem [longint];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int s);
        return (s == 0) ? 32'h0 : BASE_B;
    endfunction
    function automatic int depth_of(input int s);
        return (s == 0) ? 1024 : DEPTH_B;
    endfunction
    function automatic int wait_of(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    // Behavioural memory: byte offset from base, word = offset/4, error if misaligned or past the end.
    task automatic model_apply(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] b, output logic [31:0] er, output logic ee,
                               output logic known);
        logic [31:0] off;
        logic [31:0] word;
        longint      key;
        off   = a - base_of(s);
        ee    = (a % 4 != 0) || (longint'(off) >= 4 * longint'(depth_of(s)));
        er    = 32'h0;
        known = 1'b1;
        if (!ee) begin
            key = longint'(s) * 64'h1_0000_0000 + longint'(off / 4);
            if (w) begin
                word = model_mem.exists(key) ? model_mem[key] : 32'h0;
                for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
                model_mem[key] = word;
            end else if (model_mem.exists(key)) begin
                er = model_mem[key];
            end else begin
                known = 1'b0;
            end
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        #1;
        while (gnt_m !== 1'b1 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, " gnt"}, gnt_m, 1'b1);
    endtask

    // Called while the grant cycle is being sampled; the next rising edge accepts the request.
    task automatic finish_txn(input string tag, input logic [31:0] er, input logic ee, input logic known);
        int lat;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (rvalid_m !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, wait_of(sel) + 1);
        check({tag, " err"}, err_m, ee);
        if (known) check({tag, " rdata"}, rdata_m, er);
        @(posedge clk); #1;
        check({tag, " idle outputs"}, {rvalid_m, err_m, rdata_m}, 34'h0);
    endtask

    task automatic do_txn(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        logic [31:0] er;
        logic        ee, known;
        model_apply(sel, w, a, d, b, er, ee, known);
        issue(w, a, d, b);
        wait_gnt(tag);
        finish_txn(tag, er, ee, known);
    endtask

    function automatic logic [31:0] pick_addr(input int s);
        logic [31:0] bs;
        int          dp;
        bs = base_of(s);
        dp = depth_of(s);
        case ($urandom_range(0, 9))
            6:       return bs + 32'(4 * (dp - 1));
            7:       return bs + 32'(4 * dp);
            8:       return bs - 32'd4;
            9:       return bs + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            default: return bs + 32'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    task automatic prefill(input int s);
        for (int i = 0; i < 16; i++) do_txn("prefill", 1'b1, base_of(s) + 32'(4 * i), $urandom, 4'hF);
        do_txn("prefill last", 1'b1, base_of(s) + 32'(4 * (depth_of(s) - 1)), $urandom, 4'hF);
    endtask

    task automatic random_txns(input int n);
        for (int i = 0; i < n; i++)
            do_txn("random", 1'($urandom_range(0, 1)), pick_addr(sel), $urandom, 4'($urandom_range(0, 15)));
    endtask

    initial begin
        logic [31:0] er;
        logic        ee, known;
        int          seen, n_g, n_r;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0; sel = 0;
        #23;
        check("reset outputs a", {gnt_a, rvalid_a, err_a, ready_a, rdata_a}, 36'h0);
        check("reset outputs b", {gnt_b, rvalid_b, err_b, ready_b, rdata_b}, 36'h0);

        // Startup with req held: five cycles of gnt=0/ready=0, then grant.
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF; be = 4'hF;
        model_apply(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, er, ee, known);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("startup cycle 0", {gnt_a, ready_a}, 2'b00);
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #1;
            check("startup hold", {gnt_a, ready_a}, 2'b00);
        end
        @(posedge clk); #1;
        check("startup first gnt", {gnt_a, ready_a}, 2'b11);
        finish_txn("write 0x10", er, ee, known);

        do_txn("read 0x10", 1'b0, 32'h10, 32'h0, 4'h0);
        do_txn("byte write 0x10", 1'b1, 32'h10, 32'h0000_00AA, 4'b0001);
        do_txn("read merged 0x10", 1'b0, 32'h10, 32'h0, 4'h0);
        do_txn("read misaligned", 1'b0, 32'h12, 32'h0, 4'h0);
        do_txn("read out of range", 1'b0, 32'h1000, 32'h0, 4'h0);
        do_txn("write 0x0", 1'b1, 32'h0, 32'h1357_9BDF, 4'hF);
        do_txn("write out of range", 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF);
        do_txn("read 0x0 unaliased", 1'b0, 32'h0, 32'h0, 4'h0);
        do_txn("write be=0", 1'b1, 32'h0, 32'h2468_ACE0, 4'h0);
        do_txn("read 0x0 after be=0", 1'b0, 32'h0, 32'h0, 4'h0);

        prefill(0);
        random_txns(40);

        // Reset during WAIT aborts the write to 0x20.
        issue(1'b1, 32'h20, 32'h1234_5678, 4'hF);
        wait_gnt("abort write");
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        #1;
        check("reset in wait", {gnt_a, rvalid_a, err_a, ready_a, rdata_a}, 36'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rvalid_a === 1'b1) seen++;
        end
        check("no rvalid after abort", seen, 0);
        do_txn("read 0x20 after abort", 1'b0, 32'h20, 32'h0, 4'h0);

        // Zero-wait instance with offset base.
        sel = 1;
        prefill(1);
        random_txns(30);

        model_apply(1, 1'b0, BASE_B, 32'h0, 4'h0, er, ee, known);
        issue(1'b0, BASE_B, 32'h0, 4'h0);
        wait_gnt("back-to-back");
        n_g = 0;
        n_r = 0;
        for (int k = 0; k < 10; k++) begin
            check("back-to-back pattern", {gnt_b, rvalid_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (rvalid_b === 1'b1) check("back-to-back rdata", {err_b, rdata_b}, {1'b0, er});
            if (gnt_b === 1'b1) n_g++;
            if (rvalid_b === 1'b1) n_r++;
            @(negedge clk); #1;
        end
        check("one response per grant", n_r, n_g);
        req = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states between grant and response (range 0..15).
REQ-004 SHALL have parameter STARTUP_CYCLES, default 5, post-reset cycles before first grant (range 1..15).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req  input  1  initiator request valid.
REQ-008 SHALL have port we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wdata  input  32  write data.
REQ-011 SHALL have port be  input  4  byte enables; be[i] selects wdata[8i+7:8i].
REQ-012 SHALL have port gnt  output  1  request accepted this cycle.
REQ-013 SHALL have port rvalid  output  1  response valid, one-cycle pulse.
REQ-014 SHALL have port rdata  output  32  read data.
REQ-015 SHALL have port err  output  1  error flag, qualified by rvalid.
REQ-016 SHALL have port ready  output  1  startup complete, high in IDLE/WAIT/RESP.

Function
REQ-017 SHALL implement states STARTUP, IDLE, WAIT, RESP with a 4-bit down-counter cnt.
REQ-018 STARTUP: gnt=0; cnt loaded with STARTUP_CYCLES-1 on reset, decremented each cycle; cnt==0 -> IDLE.
REQ-019 IDLE: gnt = req (combinational, no other term); on req=1 SHALL latch we, addr, wdata, be.
REQ-020 IDLE with req=1: WAIT_CYCLES==0 -> RESP, else -> WAIT with cnt=WAIT_CYCLES-1; req=0 -> stay IDLE.
REQ-021 WAIT: gnt=0; cnt decrements; cnt==0 -> RESP; req ignored, latched transaction completes.
REQ-022 RESP: gnt=0; rvalid=1 for exactly this cycle; next state IDLE unconditionally (no back-to-back grant).
REQ-023 rvalid, rdata, err SHALL be registered, updated on the edge entering RESP, and rdata=0, err=0, rvalid=0 in every non-RESP cycle.
REQ-024 Latency: request granted at cycle N -> rvalid at cycle N+WAIT_CYCLES+1; max throughput one transaction per WAIT_CYCLES+2 cycles.
REQ-025 Word index SHALL be (latched addr - BASE_ADDR) >> 2, computed modulo 2^32.
REQ-026 err=1 when latched addr[1:0]!=0 or (addr - BASE_ADDR) >= 4*DEPTH_WORDS (addresses below BASE_ADDR wrap and fail this test).
REQ-027 Error transaction: no memory write; rdata=0; err=1; rvalid=1.
REQ-028 Valid read: rdata = stored word at index; err=0.
REQ-029 Valid write: committed on the edge entering RESP; only bytes with be[i]=1 change; rdata=0; err=0.
REQ-030 Write with be=4'b0000: no memory change, normal response (rvalid=1, err=0).
REQ-031 Read in a later transaction SHALL return data of all previously committed writes.
REQ-032 Memory array SHALL NOT be reset; contents undefined until written.

Reset
REQ-033 rst=1 SHALL immediately force state=STARTUP, cnt=STARTUP_CYCLES-1, gnt=0, rvalid=0, rdata=0, err=0, ready=0.
REQ-034 Reset during WAIT SHALL abort the transaction: no write committed, no rvalid after reset release.
REQ-035 After rst deassertion, first cycle with gnt possible is cycle STARTUP_CYCLES (counting the first post-reset edge as cycle 1).

Verification
REQ-036 Reset release, req=1 held -> gnt=0 and ready=0 for 5 cycles, then gnt=1, ready=1 (defaults).
REQ-037 Write addr=0x10, wdata=0xDEADBEEF, be=4'hF; then read 0x10 -> rvalid exactly 3 cycles after each grant, rdata=0xDEADBEEF, err=0.
REQ-038 Write addr=0x10, wdata=0x000000AA, be=4'b0001 over 0xDEADBEEF -> read 0x10 returns 0xDEADBEAA.
REQ-039 Read addr=0x12 and read addr=0x1000 (DEPTH_WORDS=1024) -> rvalid=1, err=1, rdata=0; write to 0x1000 leaves memory unchanged.
REQ-040 Write 0x20 granted, rst pulsed during WAIT -> no rvalid; after startup, read 0x20 returns prior contents (not new wdata).
REQ-041 req held high continuously with WAIT_CYCLES=0 -> gnt pattern 1,0,1,0..., rvalid pattern 0,1,0,1..., one response per grant.
